// File: rtl/aoc_2_range_enumerator_if.sv
// -----------------------------------------------------------------------------
// aoc_2_range_enumerator_if
// Bundles the range-input handshake, the ID-output handshake and the status
// and statistics outputs of the range enumerator.
//
// Parameter:
//   W            width of range bounds, IDs and the ID counter
// Signals:
//   range_start  first ID of the range (inclusive)
//   range_end    last ID of the range (inclusive)
//   range_valid  a range is offered
//   range_ready  enumerator can accept a range
//   abort        drop the range currently being enumerated
//   id_value     ID presented downstream
//   valid_id     id_value is valid
//   id_ready     downstream accepts id_value
//   busy         a range is in progress
//   range_done   one-cycle pulse: range finished, empty or aborted
//   range_err    one-cycle pulse: accepted range had start > end
//   ranges_done  completed-range counter
//   ids_emitted  transferred-ID counter
// Modports:
//   master       the side that offers ranges and consumes IDs
//   slave        the enumerator itself
// -----------------------------------------------------------------------------
interface aoc_2_range_enumerator_if #(
    parameter int W = 64
);
    logic [W-1:0] range_start;
    logic [W-1:0] range_end;
    logic         range_valid;
    logic         range_ready;
    logic         abort;
    logic [W-1:0] id_value;
    logic         valid_id;
    logic         id_ready;
    logic         busy;
    logic         range_done;
    logic         range_err;
    logic [31:0]  ranges_done;
    logic [W-1:0] ids_emitted;

    modport master (
        output range_start, range_end, range_valid, abort, id_ready,
        input  range_ready, id_value, valid_id, busy, range_done, range_err,
               ranges_done, ids_emitted
    );

    modport slave (
        input  range_start, range_end, range_valid, abort, id_ready,
        output range_ready, id_value, valid_id, busy, range_done, range_err,
               ranges_done, ids_emitted
    );
endinterface

// File: rtl/aoc_2_range_enumerator.sv
// -----------------------------------------------------------------------------
// aoc_2_range_enumerator
// Accepts an inclusive ID range and emits every ID in it, one per accepted
// transfer, using a valid/ready handshake towards the checker stage.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous, active-low reset
//   bus    aoc_2_range_enumerator_if.slave (see interface file for signals)
//
// Configuration:
//   AOC2_ENUM_STATS_EN  when defined, ranges_done counts range_done pulses and
//                       ids_emitted counts ID transfers; otherwise both are
//                       tied to zero and no counter logic exists.
// -----------------------------------------------------------------------------
module aoc_2_range_enumerator #(
    parameter int W = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    aoc_2_range_enumerator_if.slave   bus
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t       state;
    state_t       state_next;
    logic [W-1:0] id_q;
    logic [W-1:0] end_q;
    logic         done_q;
    logic         err_q;

    logic         accept;
    logic         bad_range;
    logic         xfer;
    logic         last_xfer;
    logic         done_set;

    // Handshake decode. Termination compares against the latched end only,
    // so an end bound of all-ones never needs the counter to wrap.
    assign accept    = (state == IDLE) && bus.range_valid;
    assign bad_range = bus.range_start > bus.range_end;
    assign xfer      = (state == EMIT) && bus.id_ready;
    assign last_xfer = xfer && (id_q == end_q);
    assign done_set  = (accept && bad_range) ||
                       ((state == EMIT) && (bus.abort || last_xfer));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort wins over continuing the range
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && !bad_range) state_next = EMIT;
            EMIT: if (bus.abort || last_xfer) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latched bounds, current ID and the completion pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q   <= '0;
            end_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= done_set;
            err_q  <= accept && bad_range;
            if (accept) begin
                id_q  <= bus.range_start;
                end_q <= bus.range_end;
            end else if (xfer && !bus.abort && !last_xfer) begin
                id_q <= id_q + W'(1);
            end
        end
    end

    // Output decode
    always_comb begin
        bus.range_ready = (state == IDLE);
        bus.valid_id    = (state == EMIT);
        bus.busy        = (state == EMIT);
        bus.id_value    = id_q;
        bus.range_done  = done_q;
        bus.range_err   = err_q;
    end

`ifdef AOC2_ENUM_STATS_EN
    logic [31:0]  ranges_cnt;
    logic [W-1:0] ids_cnt;

    // Counters advance on the same edge that raises range_done or moves an ID
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ranges_cnt <= '0;
            ids_cnt    <= '0;
        end else begin
            if (done_set) ranges_cnt <= ranges_cnt + 32'd1;
            if (xfer)     ids_cnt    <= ids_cnt + W'(1);
        end
    end

    assign bus.ranges_done = ranges_cnt;
    assign bus.ids_emitted = ids_cnt;
`else
    assign bus.ranges_done = '0;
    assign bus.ids_emitted = '0;
`endif

endmodule

// File: tb/tb_aoc_2_range_enumerator.sv
// -----------------------------------------------------------------------------
// tb_aoc_2_range_enumerator
// Table-driven bench for aoc_2_range_enumerator. Each table row offers one
// range and a small cycle model predicts valid/ready/done/err and the ID on
// every cycle. Reset behaviour is covered by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_aoc_2_range_enumerator;

    localparam int W = 64;
    localparam logic [W-1:0] MAXV = '1;
`ifdef AOC2_ENUM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] r_start;
        logic [W-1:0] r_end;
        bit           toggle_ready;
        int           abort_at;
        bit           abort_offer;
        bit           hold_valid;
        int           exp_ids;
        bit           exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    aoc_2_range_enumerator_if #(.W(W)) bus ();

    aoc_2_range_enumerator #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [31:0]  tot_ranges;
    logic [W-1:0] tot_ids;
    vec_t         vecs[9];

    // One comparison; prints a FAIL line on mismatch
    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkStats();
        checkOutput("ranges_done", 64'(bus.ranges_done), STATS ? 64'(tot_ranges) : 64'd0);
        checkOutput("ids_emitted", bus.ids_emitted, STATS ? tot_ids : '0);
    endtask

    // Offer one range and follow it cycle by cycle against the model
    task automatic applyStimulus(input vec_t v);
        logic [W-1:0] exp_id;
        bit exp_busy, exp_done, exp_err, rdy, finished;
        int nx, obs, quiet;

        @(negedge clk);
        checkOutput("ready_before", 64'(bus.range_ready), 64'd1);
        bus.range_start = v.r_start;
        bus.range_end   = v.r_end;
        bus.range_valid = 1'b1;
        bus.abort       = v.abort_offer;
        bus.id_ready    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.range_valid = v.hold_valid;
        bus.range_start = v.hold_valid ? 64'd60 : ~v.r_start;
        bus.range_end   = v.hold_valid ? 64'd60 : ~v.r_end;
        bus.abort       = 1'b0;

        exp_busy = (v.r_start <= v.r_end);
        exp_done = !exp_busy;
        exp_err  = !exp_busy;
        exp_id   = v.r_start;
        if (exp_done) tot_ranges++;
        nx = 0; obs = 0; quiet = 0; finished = 1'b0;

        for (int k = 0; k < 200; k++) begin
            checkOutput("valid_id", 64'(bus.valid_id), 64'(exp_busy));
            checkOutput("busy", 64'(bus.busy), 64'(exp_busy));
            checkOutput("range_ready", 64'(bus.range_ready), 64'(!exp_busy));
            checkOutput("range_done", 64'(bus.range_done), 64'(exp_done));
            checkOutput("range_err", 64'(bus.range_err), 64'(exp_err));
            if (exp_busy) checkOutput("id_value", bus.id_value, exp_id);
            if (!exp_busy && !exp_done) quiet++; else quiet = 0;
            if (quiet >= 3) begin
                finished = 1'b1;
                break;
            end
            exp_done = 1'b0;
            exp_err  = 1'b0;
            bus.id_ready = 1'b0;
            bus.abort    = 1'b0;
            if (exp_busy) begin
                rdy = !v.toggle_ready || (k % 2 == 0);
                bus.id_ready = rdy;
                if (rdy) begin
                    if (bus.valid_id) obs++;
                    nx++;
                    tot_ids++;
                    if (v.abort_at != 0 && nx == v.abort_at) begin
                        bus.abort = 1'b1;
                        exp_busy  = 1'b0;
                        exp_done  = 1'b1;
                    end else if (exp_id == v.r_end) begin
                        exp_busy = 1'b0;
                        exp_done = 1'b1;
                    end else begin
                        exp_id++;
                    end
                end
            end
            if (exp_done) tot_ranges++;
            bus.range_valid = v.hold_valid && exp_busy;
            @(posedge clk);
            @(negedge clk);
        end
        bus.id_ready = 1'b0;
        bus.abort    = 1'b0;
        checkOutput("range_finished", 64'(finished), 64'd1);
        checkOutput("id_count", 64'(obs), 64'(v.exp_ids));
        checkStats();
    endtask

    initial begin
        vecs[0] = '{64'd11, 64'd22, 1'b0, 0, 1'b0, 1'b0, 12, 1'b0};
        vecs[1] = '{64'd95, 64'd115, 1'b1, 0, 1'b0, 1'b0, 21, 1'b0};
        vecs[2] = '{64'd30, 64'd20, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1};
        vecs[3] = '{MAXV - 64'd2, MAXV, 1'b0, 0, 1'b0, 1'b0, 3, 1'b0};
        vecs[4] = '{64'd1, 64'd1000, 1'b0, 5, 1'b0, 1'b0, 5, 1'b0};
        vecs[5] = '{64'd7, 64'd7, 1'b0, 0, 1'b0, 1'b0, 1, 1'b0};
        vecs[6] = '{64'd40, 64'd41, 1'b0, 0, 1'b1, 1'b0, 2, 1'b0};
        vecs[7] = '{64'd50, 64'd52, 1'b1, 0, 1'b0, 1'b1, 3, 1'b0};
        vecs[8] = '{MAXV, MAXV, 1'b0, 0, 1'b0, 1'b0, 1, 1'b0};

        rst_n = 1'b0;
        bus.range_start = '0;
        bus.range_end   = '0;
        bus.range_valid = 1'b0;
        bus.abort       = 1'b0;
        bus.id_ready    = 1'b0;
        tot_ranges = '0;
        tot_ids    = '0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_valid_id", 64'(bus.valid_id), 64'd0);
        checkOutput("rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_id_value", bus.id_value, 64'd0);
        checkOutput("rst_range_done", 64'(bus.range_done), 64'd0);
        checkOutput("rst_range_err", 64'(bus.range_err), 64'd0);
        checkStats();
        rst_n = 1'b1;
        #1;
        checkOutput("ready_after_rst", 64'(bus.range_ready), 64'd1);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
        end

        // Reset in the middle of range 1-100
        @(negedge clk);
        bus.range_start = 64'd1;
        bus.range_end   = 64'd100;
        bus.range_valid = 1'b1;
        bus.id_ready    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.range_valid = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("mid_id_value", bus.id_value, 64'd6);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid_id", 64'(bus.valid_id), 64'd0);
        checkOutput("mid_rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("mid_rst_id_value", bus.id_value, 64'd0);
        checkOutput("mid_rst_range_done", 64'(bus.range_done), 64'd0);
        tot_ranges = '0;
        tot_ids    = '0;
        checkStats();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("mid_ready_after_rst", 64'(bus.range_ready), 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("post_rst_range_done", 64'(bus.range_done), 64'd0);
            checkOutput("post_rst_valid_id", 64'(bus.valid_id), 64'd0);
        end
        bus.id_ready = 1'b0;
        applyStimulus(vecs[5]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global guard against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/aoc_2_range_enumerator.md
AOC_2_RANGE_ENUMERATOR -- requirements
Module: aoc_2_range_enumerator

Interface
REQ-001 Parameter: W, 64, width of range bounds and emitted IDs.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 range_start  input  W  first ID of range (inclusive).
REQ-005 range_end  input  W  last ID of range (inclusive).
REQ-006 range_valid  input  1  range_start/range_end present.
REQ-007 range_ready  output  1  block can accept a range.
REQ-008 abort  input  1  synchronous request to drop current range.
REQ-009 id_value  output  W  ID presented to checker stage.
REQ-010 valid_id  output  1  id_value valid this cycle.
REQ-011 id_ready  input  1  checker accepts id_value this cycle.
REQ-012 busy  output  1  range in progress.
REQ-013 range_done  output  1  one-cycle pulse when a range completes, is empty or is aborted.
REQ-014 range_err  output  1  one-cycle pulse when accepted range has range_start > range_end.
REQ-015 ranges_done  output  32  completed-range counter (see Configuration).
REQ-016 ids_emitted  output  W  accepted-ID counter (see Configuration).

Function
REQ-017 FSM states IDLE and EMIT; range_ready = (state==IDLE); busy = valid_id = (state==EMIT).
REQ-018 Range accepted on the rising edge where range_valid && range_ready; bounds latched internally; input changes afterwards have no effect.
REQ-019 Accepted range with range_start <= range_end: next state EMIT, id_value = range_start; first valid_id one cycle after acceptance.
REQ-020 Accepted range with range_start > range_end: stay IDLE, pulse range_err and range_done in the next cycle, emit no IDs.
REQ-021 ID transfer occurs on a rising edge with valid_id && id_ready; without transfer, id_value and valid_id hold stable.
REQ-022 On transfer with id_value != latched end: id_value increments by 1, state stays EMIT (back-to-back throughput one ID per cycle).
REQ-023 On transfer with id_value == latched end: state IDLE, valid_id low, range_done pulses next cycle; range_ready high next cycle.
REQ-024 Termination uses equality with latched end only; range_end = 2^W-1 completes without overflow or wrap.
REQ-025 Single-ID range (start == end) emits exactly one ID.
REQ-026 abort in EMIT: next state IDLE, range_done pulses; abort has priority over increment; a coincident transfer still counts as accepted.
REQ-027 abort in IDLE ignored; a range offered with range_valid in the same cycle as abort in IDLE is still accepted.
REQ-028 No range is accepted while in EMIT (no prefetch).

Reset
REQ-029 While rst_n low: state IDLE, id_value 0, valid_id 0, busy 0, range_done 0, range_err 0, ranges_done 0, ids_emitted 0, latched bounds 0.
REQ-030 range_ready is 1 from the first cycle after rst_n deasserts.
REQ-031 Reset asserted mid-range discards the range immediately; no range_done pulse.

Configuration
REQ-032 Macro AOC2_ENUM_STATS_EN: defined -> ranges_done increments on every range_done pulse (wraps at 2^32), ids_emitted increments on every ID transfer (wraps at 2^W).
REQ-033 Macro not defined -> ranges_done and ids_emitted ports remain present and are tied to 0; no counter logic is instantiated.

Verification
REQ-034 Range 11-22, id_ready held 1 -> valid_id 12 consecutive cycles, IDs 11..22, one range_done, ids_emitted=12 (stats on).
REQ-035 Range 95-115, id_ready toggled 1/0 each cycle -> every ID 95..115 emitted exactly once, id_value stable during stalls.
REQ-036 Range 30-20 -> no valid_id, range_err and range_done each pulse once, ranges_done=1.
REQ-037 Range 2^64-3 to 2^64-1 -> exactly 3 IDs, returns to IDLE, no further valid_id.
REQ-038 Range 1-1000, abort on 5th accepted ID with id_ready=1 -> ids_emitted=5, IDLE next cycle, next range 7-7 emits single ID 7.
REQ-039 rst_n pulsed low during range 1-100 -> all outputs 0, no range_done; range_ready=1 after release.
